// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Pipeline sequencer for the 5-stage LEGv8 core. It owns every write enable,
//   flush and bubble control of the IF/ID, ID/EX, EX/MEM and MEM/WB registers
//   and resolves load-use, taken-branch and data-memory-busy hazards. It also
//   produces the ALU operand forwarding selects.
//
// Parameters
//   FLUSH_CYCLES  front-end flush cycles per taken branch (1..3)
//   CNT_W         width of the saturating performance counters
//
// Ports
//   clk, reset                     rising-edge clock, async active-high reset
//   id_Rn/id_Rm, id_uses_rn/rm     sources of the instruction in ID
//   ex_Rn/ex_Rm/ex_Rd, ex_MemRead  operands, destination and load flag in ID/EX
//   mem_Rd, mem_RegWrite           destination held in EX/MEM
//   mem_br_taken, mem_busy         branch resolution and data memory stall
//   wb_Rd, wb_RegWrite             destination held in MEM/WB
//   pc_write, ifid_write           front-end load enables
//   ifid_flush, idex_bubble        IF/ID clear and ID/EX NOP injection
//   exmem_flush, pipe_hold         EX/MEM clear and back-end freeze
//   fwd_a, fwd_b                   ALU operand selects (00 RF, 10 EX/MEM, 01 MEM/WB)
//   stall_cnt, flush_cnt           saturating stall-cycle and branch-flush counts

module hazard_ctrl_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_Rn,
  input  logic [4:0]       id_Rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic [4:0]       ex_Rn,
  input  logic [4:0]       ex_Rm,
  input  logic [4:0]       ex_Rd,
  input  logic             ex_MemRead,
  input  logic [4:0]       mem_Rd,
  input  logic             mem_RegWrite,
  input  logic             mem_br_taken,
  input  logic             mem_busy,
  input  logic [4:0]       wb_Rd,
  input  logic             wb_RegWrite,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             pipe_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] BR_FLUSH = 2'd2;

  localparam logic [4:0] XZR = 5'd31;

  // Remaining flush cycles loaded on the branch cycle itself.
  localparam logic [1:0] FL_INIT = 2'(FLUSH_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       fl_cnt_q, fl_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic br_event;

  // XZR is hardwired zero, so a load into X31 can never create a dependency.
  always_comb begin
    load_use = ex_MemRead && (ex_Rd != XZR) &&
               ((id_uses_rn && (id_Rn == ex_Rd)) ||
                (id_uses_rm && (id_Rm == ex_Rd)));
  end

  // The younger producer (EX/MEM) has priority over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    if (mem_RegWrite && (mem_Rd != XZR) && (mem_Rd == ex_Rn)) begin
      fwd_a = 2'b10;
    end else if (wb_RegWrite && (wb_Rd != XZR) && (wb_Rd == ex_Rn)) begin
      fwd_a = 2'b01;
    end

    fwd_b = 2'b00;
    if (mem_RegWrite && (mem_Rd != XZR) && (mem_Rd == ex_Rm)) begin
      fwd_b = 2'b10;
    end else if (wb_RegWrite && (wb_Rd != XZR) && (wb_Rd == ex_Rm)) begin
      fwd_b = 2'b01;
    end
  end

  // Sequencer: MEM_WAIT with memory still busy freezes everything and ignores
  // the branch input; MEM_WAIT with memory ready behaves exactly like RUN.
  // During BR_FLUSH the front end holds only squashed instructions, so busy
  // and load-use are irrelevant there.
  always_comb begin
    state_d     = state_q;
    fl_cnt_d    = fl_cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    pipe_hold   = 1'b0;
    br_event    = 1'b0;

    if (state_q == BR_FLUSH) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      fl_cnt_d    = fl_cnt_q - 2'd1;
      if (fl_cnt_q == 2'd1) begin
        state_d = RUN;
      end
    end else if ((state_q == MEM_WAIT) && mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end else begin
      state_d = RUN;
      if (mem_br_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_flush = 1'b1;
        br_event    = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d  = BR_FLUSH;
          fl_cnt_d = FL_INIT;
        end
      end else if (mem_busy) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        pipe_hold  = 1'b1;
        state_d    = MEM_WAIT;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (br_event && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      fl_cnt_q    <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fl_cnt_q    <= fl_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit
//   Bench for hazard_ctrl_unit built with FLUSH_CYCLES=3 and CNT_W=4 so that
//   multi-cycle branch flushes and counter saturation are both reachable.

module tb_hazard_ctrl_unit;

  localparam int FLUSH_CYCLES = 3;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_Rn, id_Rm, ex_Rn, ex_Rm, ex_Rd, mem_Rd, wb_Rd;
  logic       id_uses_rn, id_uses_rm, ex_MemRead, mem_RegWrite;
  logic       mem_br_taken, mem_busy, wb_RegWrite;

  logic             pc_write, ifid_write, ifid_flush, idex_bubble;
  logic             exmem_flush, pipe_hold;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0] id_Rn;
    logic [4:0] id_Rm;
    logic       id_uses_rn;
    logic       id_uses_rm;
    logic [4:0] ex_Rn;
    logic [4:0] ex_Rm;
    logic [4:0] ex_Rd;
    logic       ex_MemRead;
    logic [4:0] mem_Rd;
    logic       mem_RegWrite;
    logic       mem_br_taken;
    logic       mem_busy;
    logic [4:0] wb_Rd;
    logic       wb_RegWrite;
  } stim_t;

  hazard_ctrl_unit #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_Rn(id_Rn),
    .id_Rm(id_Rm),
    .id_uses_rn(id_uses_rn),
    .id_uses_rm(id_uses_rm),
    .ex_Rn(ex_Rn),
    .ex_Rm(ex_Rm),
    .ex_Rd(ex_Rd),
    .ex_MemRead(ex_MemRead),
    .mem_Rd(mem_Rd),
    .mem_RegWrite(mem_RegWrite),
    .mem_br_taken(mem_br_taken),
    .mem_busy(mem_busy),
    .wb_Rd(wb_Rd),
    .wb_RegWrite(wb_RegWrite),
    .pc_write(pc_write),
    .ifid_write(ifid_write),
    .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble),
    .exmem_flush(exmem_flush),
    .pipe_hold(pipe_hold),
    .fwd_a(fwd_a),
    .fwd_b(fwd_b),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  // Free-running 10-time-unit clock; rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t",
               name, actual, expected, $time);
    end
  endtask

  function automatic stim_t idleVec();
    stim_t v;
    v = '0;
    return v;
  endfunction

  // Inputs change 1 unit after a rising edge; outputs settle before the checks.
  task automatic applyStimulus(input stim_t v);
    id_Rn        = v.id_Rn;
    id_Rm        = v.id_Rm;
    id_uses_rn   = v.id_uses_rn;
    id_uses_rm   = v.id_uses_rm;
    ex_Rn        = v.ex_Rn;
    ex_Rm        = v.ex_Rm;
    ex_Rd        = v.ex_Rd;
    ex_MemRead   = v.ex_MemRead;
    mem_Rd       = v.mem_Rd;
    mem_RegWrite = v.mem_RegWrite;
    mem_br_taken = v.mem_br_taken;
    mem_busy     = v.mem_busy;
    wb_Rd        = v.wb_Rd;
    wb_RegWrite  = v.wb_RegWrite;
    #2;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour: a count of flush cycles still owed, a flag for a
  // memory freeze in progress, and plain integer event counters.
  int flush_left = 0;
  bit held = 1'b0;
  int stalls = 0;
  int flushes = 0;

  function automatic bit regHit(input logic [4:0] producer, input logic [4:0] src);
    return (producer != 5'd31) && (producer == src);
  endfunction

  function automatic logic [1:0] fwdSel(input logic [4:0] src);
    if (mem_RegWrite && regHit(mem_Rd, src)) return 2'b10;
    if (wb_RegWrite && regHit(wb_Rd, src)) return 2'b01;
    return 2'b00;
  endfunction

  // Compares every output against the reference on each falling edge and then
  // advances the reference past the coming rising edge.
  always @(negedge clk) begin
    bit e_pc, e_ifw, e_iff, e_bub, e_exf, e_hold, br_ev, lu;
    if (reset) begin
      flush_left = 0;
      held       = 1'b0;
      stalls     = 0;
      flushes    = 0;
    end
    lu = ex_MemRead && ((id_uses_rn && regHit(ex_Rd, id_Rn)) ||
                        (id_uses_rm && regHit(ex_Rd, id_Rm)));
    e_pc = 1; e_ifw = 1; e_iff = 0; e_bub = 0; e_exf = 0; e_hold = 0; br_ev = 0;
    if (flush_left > 0) begin
      e_iff = 1; e_bub = 1;
    end else if (held && mem_busy) begin
      e_pc = 0; e_ifw = 0; e_hold = 1;
    end else if (mem_br_taken) begin
      e_iff = 1; e_bub = 1; e_exf = 1; br_ev = 1;
    end else if (mem_busy) begin
      e_pc = 0; e_ifw = 0; e_hold = 1;
    end else if (lu) begin
      e_pc = 0; e_ifw = 0; e_bub = 1;
    end

    checkOutput("model pc_write",    16'(pc_write),    16'(e_pc));
    checkOutput("model ifid_write",  16'(ifid_write),  16'(e_ifw));
    checkOutput("model ifid_flush",  16'(ifid_flush),  16'(e_iff));
    checkOutput("model idex_bubble", 16'(idex_bubble), 16'(e_bub));
    checkOutput("model exmem_flush", 16'(exmem_flush), 16'(e_exf));
    checkOutput("model pipe_hold",   16'(pipe_hold),   16'(e_hold));
    checkOutput("model fwd_a",       16'(fwd_a),       16'(fwdSel(ex_Rn)));
    checkOutput("model fwd_b",       16'(fwd_b),       16'(fwdSel(ex_Rm)));
    checkOutput("model stall_cnt",   16'(stall_cnt),   16'(stalls));
    checkOutput("model flush_cnt",   16'(flush_cnt),   16'(flushes));

    if (!reset) begin
      if (flush_left > 0) flush_left--;
      else if (br_ev) flush_left = FLUSH_CYCLES - 1;
      held = e_hold;
      if (!e_pc && stalls < CNT_MAX) stalls++;
      if (br_ev && flushes < CNT_MAX) flushes++;
    end
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    stim_t v;

    applyStimulus(idleVec());
    nextCycle();
    checkOutput("reset pc_write",   16'(pc_write),   16'd1);
    checkOutput("reset ifid_write", 16'(ifid_write), 16'd1);
    checkOutput("reset pipe_hold",  16'(pipe_hold),  16'd0);
    checkOutput("reset stall_cnt",  16'(stall_cnt),  16'd0);
    checkOutput("reset flush_cnt",  16'(flush_cnt),  16'd0);
    reset = 1'b0;
    nextCycle();

    // LDUR X2 in EX, ADD X3,X2,X4 in ID: one stall cycle.
    v = idleVec();
    v.id_Rn = 5'd2; v.id_Rm = 5'd4; v.id_uses_rn = 1; v.id_uses_rm = 1;
    v.ex_Rd = 5'd2; v.ex_MemRead = 1;
    applyStimulus(v);
    checkOutput("loaduse pc_write",    16'(pc_write),    16'd0);
    checkOutput("loaduse ifid_write",  16'(ifid_write),  16'd0);
    checkOutput("loaduse idex_bubble", 16'(idex_bubble), 16'd1);
    nextCycle();
    v.ex_Rd = 5'd0; v.ex_MemRead = 0; v.mem_Rd = 5'd2; v.mem_RegWrite = 1;
    applyStimulus(v);
    checkOutput("post-stall pc_write", 16'(pc_write), 16'd1);
    nextCycle();
    v = idleVec();
    v.ex_Rn = 5'd2; v.ex_Rm = 5'd4; v.wb_Rd = 5'd2; v.wb_RegWrite = 1;
    applyStimulus(v);
    checkOutput("load fwd_a wb",  16'(fwd_a),     16'd1);
    checkOutput("load fwd_b rf",  16'(fwd_b),     16'd0);
    checkOutput("stall_cnt one",  16'(stall_cnt), 16'd1);
    nextCycle();

    // X5 in both EX/MEM and MEM/WB: EX/MEM wins.
    v = idleVec();
    v.ex_Rn = 5'd5; v.ex_Rm = 5'd5;
    v.mem_Rd = 5'd5; v.mem_RegWrite = 1; v.wb_Rd = 5'd5; v.wb_RegWrite = 1;
    applyStimulus(v);
    checkOutput("fwd_a exmem prio", 16'(fwd_a), 16'd2);
    checkOutput("fwd_b exmem prio", 16'(fwd_b), 16'd2);
    nextCycle();
    v.ex_Rm = 5'd31; v.wb_Rd = 5'd31;
    applyStimulus(v);
    checkOutput("fwd_b xzr", 16'(fwd_b), 16'd0);
    checkOutput("fwd_a still exmem", 16'(fwd_a), 16'd2);
    nextCycle();
    v = idleVec();
    v.ex_Rn = 5'd5; v.mem_Rd = 5'd5; v.wb_Rd = 5'd5; v.wb_RegWrite = 1;
    applyStimulus(v);
    checkOutput("fwd_a wb when mem no write", 16'(fwd_a), 16'd1);
    nextCycle();
    v = idleVec();
    v.ex_MemRead = 1; v.ex_Rd = 5'd31; v.id_Rn = 5'd31; v.id_uses_rn = 1;
    applyStimulus(v);
    checkOutput("xzr load no stall", 16'(pc_write), 16'd1);
    nextCycle();

    // Taken branch coinciding with a load-use: only the flush happens.
    v = idleVec();
    v.mem_br_taken = 1;
    v.id_Rn = 5'd7; v.id_uses_rn = 1; v.ex_Rd = 5'd7; v.ex_MemRead = 1;
    applyStimulus(v);
    checkOutput("br pc_write",    16'(pc_write),    16'd1);
    checkOutput("br ifid_flush",  16'(ifid_flush),  16'd1);
    checkOutput("br exmem_flush", 16'(exmem_flush), 16'd1);
    nextCycle();
    applyStimulus(idleVec());
    checkOutput("brflush1 ifid_flush",  16'(ifid_flush),  16'd1);
    checkOutput("brflush1 exmem_flush", 16'(exmem_flush), 16'd0);
    nextCycle();
    v = idleVec();
    v.mem_busy = 1;
    applyStimulus(v);
    checkOutput("brflush2 ifid_flush",   16'(ifid_flush), 16'd1);
    checkOutput("brflush2 busy ignored", 16'(pipe_hold),  16'd0);
    nextCycle();
    applyStimulus(idleVec());
    checkOutput("after flush ifid_flush", 16'(ifid_flush), 16'd0);
    checkOutput("flush_cnt one",          16'(flush_cnt),  16'd1);
    checkOutput("stall_cnt unchanged",    16'(stall_cnt),  16'd1);
    nextCycle();

    // Memory busy for four cycles; a branch while frozen is ignored.
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      v = idleVec();
      v.mem_busy = 1;
      v.mem_br_taken = (i == 1);
      applyStimulus(v);
      checkOutput("busy pipe_hold", 16'(pipe_hold), 16'd1);
      checkOutput("busy pc_write",  16'(pc_write),  16'd0);
      nextCycle();
    end
    applyStimulus(idleVec());
    checkOutput("busy done pipe_hold", 16'(pipe_hold), 16'd0);
    checkOutput("busy done pc_write",  16'(pc_write),  16'd1);
    checkOutput("busy stall_cnt",      16'(stall_cnt), 16'd4);
    checkOutput("busy flush_cnt",      16'(flush_cnt), 16'd0);
    nextCycle();

    // Asynchronous reset in the middle of a branch flush.
    v = idleVec();
    v.mem_br_taken = 1;
    applyStimulus(v);
    nextCycle();
    applyStimulus(idleVec());
    checkOutput("in BR_FLUSH ifid_flush", 16'(ifid_flush), 16'd1);
    reset = 1'b1;
    #1;
    checkOutput("midreset ifid_flush",  16'(ifid_flush),  16'd0);
    checkOutput("midreset idex_bubble", 16'(idex_bubble), 16'd0);
    checkOutput("midreset pc_write",    16'(pc_write),    16'd1);
    checkOutput("midreset stall_cnt",   16'(stall_cnt),   16'd0);
    checkOutput("midreset flush_cnt",   16'(flush_cnt),   16'd0);
    nextCycle();
    reset = 1'b0;
    nextCycle();

    // Twenty load-use stalls saturate the 4-bit stall counter.
    v = idleVec();
    v.id_Rm = 5'd9; v.id_uses_rm = 1; v.ex_Rd = 5'd9; v.ex_MemRead = 1;
    applyStimulus(v);
    repeat (20) nextCycle();
    applyStimulus(idleVec());
    checkOutput("stall_cnt saturated", 16'(stall_cnt), 16'd15);
    nextCycle();

    // Seventeen branches saturate the flush counter.
    for (int i = 0; i < 17; i++) begin
      v = idleVec();
      v.mem_br_taken = 1;
      applyStimulus(v);
      nextCycle();
      applyStimulus(idleVec());
      nextCycle();
      nextCycle();
    end
    applyStimulus(idleVec());
    checkOutput("flush_cnt saturated", 16'(flush_cnt), 16'd15);
    nextCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
